rvvi_depacketizer: RTL and testbench
====================================

// Module: rvvi_depacketizer
// PURPOSE
//  Receive-side counterpart of the RVVI trace packetizer. Consumes the 32-bit AXI-stream from the
//  Ethernet MAC RX FIFO, validates the frame header and reassembles one RVVI trace record per frame.
//  Presents the record on a valid/ready port for a host-side checker or loopback bench. Sits between
//  eth_mac_mii_fifo rx_axis_* and the trace consumer.
// PARAMETERS
//  P          cvw_t    core config; XLEN sets record width
//  MAX_CSRS   5        CSR slots per record; RVVI_W = 72+5*XLEN+MAX_CSRS*(XLEN+16)
//  ETHERTYPE  16'h005C EtherType required in header word 3, bytes 0..1
//  DEST_MAC   48'h8F54_0000_1654  accepted destination MAC; used only with the filter macro
// PORTS
//  clk           in   1       clock
//  reset         in   1       synchronous, active-high reset
//  s_axis_tdata  in   32      RX stream data; byte 0 on [7:0]
//  s_axis_tkeep  in   4       byte enables
//  s_axis_tvalid in   1       stream valid
//  s_axis_tready out  1       stream ready
//  s_axis_tlast  in   1       last word of frame
//  s_axis_tuser  in   1       MAC error flag; meaningful with tlast
//  rvvi          out  RVVI_W  reassembled record
//  rvvi_valid    out  1       record available
//  rvvi_ready    in   1       consumer accepts record
//  FrameCount    out  32      good records delivered
//  DropCount     out  32      frames discarded
// BEHAVIOUR
//  - Frame: 4 header words (dst MAC 6B, src MAC 6B, EtherType 2B, 2 pad bytes), then
//    NW=ceil(RVVI_W/32) payload words. Payload word k -> rvvi[32k+31:32k]. Bits above RVVI_W in the
//    last word are ignored. The frame carries exactly 4+NW words.
//  - Word accepted on tvalid & tready. Word counter wcnt is 0..4+NW-1, clears at frame start.
//  - FSM states: HDR, PAY, HOLD, DRAIN.
//    - HDR: tready=1. On word 3, mismatch of EtherType -> DRAIN, or -> DROP if tlast. Match -> PAY.
//      tlast in any HDR word is a short frame: drop, stay in HDR.
//    - PAY: tready=1; shift word into the record buffer.
//      - tlast before word 4+NW-1: short frame; drop -> HDR.
//      - Final word with tlast=1 & tuser=0: -> HOLD.
//      - Final word with tuser=1: drop -> HDR.
//      - Final word with tlast=0: long frame; -> DRAIN, drop counted once.
//      - tkeep!=4'hF on a non-final word: the frame is marked bad and dropped at tlast.
//    - HOLD: tready=0; rvvi_valid=1; rvvi stable. On rvvi_ready: FrameCount++ and -> HDR.
//      Earliest next-frame accept is the following cycle.
//    - DRAIN: tready=1; discard until tlast, then -> HDR.
//  - Latency: rvvi_valid rises the cycle after the final payload word handshake.
//  - Counters wrap modulo 2^32. A drop and a delivery never coincide.
//  - Reset (any state, mid-frame): state=HDR, wcnt=0, s_axis_tready=0 during reset,
//    rvvi_valid=0, rvvi='0, FrameCount=0, DropCount=0. Remainder of an interrupted frame after reset
//    is parsed as a new frame and dropped.
// CONFIGURATION
//  RVVI_DEPKT_MACFILTER_EN defined:
//    - HDR also compares words 0..1 to DEST_MAC. A mismatch drains the frame and does NOT increment
//      DropCount; the frame is treated as not addressed to us.
//  Undefined: destination MAC ignored; any destination accepted.
// STRUCTURE
//  - RVVI_W/NW localparams, header word count (4) and default EtherType live in a shared rvvi package
//    also imported by packetizer, so both ends stay consistent.
//  - One sub-module, rvvi_hdr_check: combinational header compare (EtherType, optional MAC) -> match.
//  - The record buffer is a word-indexed register array; no FIFO (single-record HOLD).
// TESTING (XLEN=64, MAX_CSRS=5: RVVI_W=792, NW=25, frame=29 words)
//  1. Good frame, EtherType 005C, tuser=0, rvvi_ready=1 -> rvvi_valid 1 cycle after word 28;
//     rvvi equals the sent payload; FrameCount=1.
//  2. Frame with EtherType 0800 -> tready held 1; no rvvi_valid; DropCount=1; next good frame delivered.
//  3. tlast on payload word 10 -> DropCount=1, state HDR. A 30-word frame -> DropCount=2, drained to tlast.
//  4. Good frame with rvvi_ready=0 for 50 cycles -> tready=0 and rvvi stable for 50 cycles;
//     delivered on ready. A back-to-back second frame is not lost.
//  5. reset asserted at payload word 12 -> all outputs 0 next cycle; trailing words dropped; then a
//     good frame is delivered.
//  6. MACFILTER_EN with dst MAC mismatch -> no delivery, DropCount unchanged. Undefined -> delivered.

Source files
------------

// File: rtl/rvvi_depacketizer_pkg.sv
// Shared RVVI trace framing definitions: record width, frame layout and header
// defaults. The packetizer imports the same package so both ends agree on the format.
package rvvi_depacketizer_pkg;

  // Minimal core-configuration view: only XLEN affects the trace record.
  typedef struct packed {
    int unsigned XLEN;
  } cvw_t;

  localparam cvw_t        CVW_DEFAULT       = '{XLEN: 64};
  localparam int          HDR_WORDS         = 4;
  localparam logic [15:0] ETHERTYPE_DEFAULT = 16'h005C;
  localparam logic [47:0] DEST_MAC_DEFAULT  = 48'h8F54_0000_1654;

  typedef enum logic [1:0] {HDR, PAY, HOLD, DRAIN} depkt_state_e;

  // Record width in bits for a given XLEN and CSR slot count.
  function automatic int rvvi_width(input int xlen, input int csrs);
    return 72 + 5 * xlen + csrs * (xlen + 16);
  endfunction

  // Number of 32-bit payload words needed to carry a record.
  function automatic int rvvi_words(input int w);
    return (w + 31) / 32;
  endfunction

endpackage

// File: rtl/rvvi_depacketizer_if.sv
// RX stream, record output and statistics bundle of the RVVI depacketizer.
// slave: the depacketizer's view; master: the MAC FIFO / consumer side.
interface rvvi_depacketizer_if #(
  parameter int RVVI_W = 792
);
  logic [31:0]       s_axis_tdata;
  logic [3:0]        s_axis_tkeep;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic              s_axis_tlast;
  logic              s_axis_tuser;
  logic [RVVI_W-1:0] rvvi;
  logic              rvvi_valid;
  logic              rvvi_ready;
  logic [31:0]       FrameCount;
  logic [31:0]       DropCount;

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser, rvvi_ready,
    output s_axis_tready, rvvi, rvvi_valid, FrameCount, DropCount
  );

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser, rvvi_ready,
    input  s_axis_tready, rvvi, rvvi_valid, FrameCount, DropCount
  );
endinterface

// File: rtl/rvvi_depacketizer_hdr_check.sv
// rvvi_hdr_check: combinational header compare for the RVVI depacketizer.
// Bytes arrive in wire order with byte 0 on [7:0], so multi-byte header fields
// (MAC, EtherType) appear byte-swapped relative to their numeric value.
// RVVI_DEPKT_MACFILTER_EN: also compare the destination MAC (words 0..1);
// otherwise mac_ok_o is tied high and the MAC inputs/parameter do not exist.
module rvvi_hdr_check import rvvi_depacketizer_pkg::*; #(
  parameter logic [15:0] ETHERTYPE = ETHERTYPE_DEFAULT
`ifdef RVVI_DEPKT_MACFILTER_EN
  , parameter logic [47:0] DEST_MAC = DEST_MAC_DEFAULT
`endif
) (
  input  logic [15:0] etype_lo_i,   // header word 3, bytes 0..1
`ifdef RVVI_DEPKT_MACFILTER_EN
  input  logic [31:0] mac_w0_i,     // header word 0: MAC bytes 0..3
  input  logic [15:0] mac_w1_i,     // header word 1: MAC bytes 4..5
`endif
  output logic        etype_ok_o,
  output logic        mac_ok_o
);

  assign etype_ok_o = (etype_lo_i == {ETHERTYPE[7:0], ETHERTYPE[15:8]});

`ifdef RVVI_DEPKT_MACFILTER_EN
  assign mac_ok_o = (mac_w0_i == {DEST_MAC[23:16], DEST_MAC[31:24], DEST_MAC[39:32], DEST_MAC[47:40]})
                 && (mac_w1_i == {DEST_MAC[7:0], DEST_MAC[15:8]});
`else
  assign mac_ok_o = 1'b1;
`endif

endmodule

// File: rtl/rvvi_depacketizer.sv
// rvvi_depacketizer: reassembles one RVVI trace record per Ethernet frame from the
// MAC RX AXI-stream and presents it on a valid/ready port with good/drop counters.
// Frame = 4 header words + NW payload words; anything else is dropped.
// RVVI_DEPKT_MACFILTER_EN: frames whose destination MAC differs from DEST_MAC are
// drained silently (not counted as drops).
module rvvi_depacketizer import rvvi_depacketizer_pkg::*; #(
  parameter cvw_t        P         = CVW_DEFAULT,
  parameter int          MAX_CSRS  = 5,
  parameter logic [15:0] ETHERTYPE = ETHERTYPE_DEFAULT
`ifdef RVVI_DEPKT_MACFILTER_EN
  , parameter logic [47:0] DEST_MAC = DEST_MAC_DEFAULT
`endif
) (
  input  logic               clk,
  input  logic               reset,
  rvvi_depacketizer_if.slave bus
);

  localparam int RVVI_W = rvvi_width(int'(P.XLEN), MAX_CSRS);
  localparam int NW     = rvvi_words(RVVI_W);
  localparam int FW     = HDR_WORDS + NW;
  localparam int WCW    = $clog2(FW);
  localparam logic [WCW-1:0] LAST_W   = WCW'(FW - 1);
  localparam logic [WCW-1:0] ETYPE_W  = WCW'(HDR_WORDS - 1);
  localparam logic [WCW-1:0] PAY_BASE = WCW'(HDR_WORDS);

  depkt_state_e      state_q;
  logic [WCW-1:0]    wcnt_q;
  logic              bad_q;
  logic              tready_q;
  logic              valid_q;
  logic [31:0]       fcnt_q;
  logic [31:0]       dcnt_q;
  logic              accept;
  logic              etype_ok;
  logic              mac_ok;
  logic              pay_ld;
  logic [WCW-1:0]    pidx;
  logic [RVVI_W-1:0] rec;

  assign accept = bus.s_axis_tvalid & tready_q;
  assign pay_ld = accept && (state_q == PAY);
  assign pidx   = wcnt_q - PAY_BASE;

`ifdef RVVI_DEPKT_MACFILTER_EN
  logic [31:0] mac0_q;
  logic [15:0] mac1_q;

  // Hold destination MAC words until the decision at header word 3.
  always_ff @(posedge clk) begin
    if (reset) begin
      mac0_q <= '0;
      mac1_q <= '0;
    end else if (accept && state_q == HDR) begin
      if (wcnt_q == WCW'(0)) mac0_q <= bus.s_axis_tdata;
      if (wcnt_q == WCW'(1)) mac1_q <= bus.s_axis_tdata[15:0];
    end
  end
`endif

  rvvi_hdr_check #(
    .ETHERTYPE (ETHERTYPE)
`ifdef RVVI_DEPKT_MACFILTER_EN
    , .DEST_MAC (DEST_MAC)
`endif
  ) u_hdr (
    .etype_lo_i (bus.s_axis_tdata[15:0]),
`ifdef RVVI_DEPKT_MACFILTER_EN
    .mac_w0_i   (mac0_q),
    .mac_w1_i   (mac1_q),
`endif
    .etype_ok_o (etype_ok),
    .mac_ok_o   (mac_ok)
  );

  // Frame parser: word counting, accept/drop decisions, handshake and counters.
  // Every drop is counted at the moment it is decided, so DRAIN never counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= HDR;
      wcnt_q   <= '0;
      bad_q    <= 1'b0;
      tready_q <= 1'b0;
      valid_q  <= 1'b0;
      fcnt_q   <= '0;
      dcnt_q   <= '0;
    end else begin
      tready_q <= (state_q != HOLD);
      case (state_q)
        HDR: if (accept) begin
          if (bus.s_axis_tlast) begin
            dcnt_q <= dcnt_q + 32'd1;
            wcnt_q <= '0;
          end else if (wcnt_q == ETYPE_W) begin
            wcnt_q <= wcnt_q + 1'b1;
            bad_q  <= 1'b0;
            if (!mac_ok) begin
              state_q <= DRAIN;          // not addressed to us: silent
            end else if (!etype_ok) begin
              state_q <= DRAIN;
              dcnt_q  <= dcnt_q + 32'd1;
            end else begin
              state_q <= PAY;
            end
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        PAY: if (accept) begin
          if (wcnt_q == LAST_W) begin
            wcnt_q <= '0;
            if (!bus.s_axis_tlast) begin
              state_q <= DRAIN;
              dcnt_q  <= dcnt_q + 32'd1;
            end else if (bus.s_axis_tuser || bad_q) begin
              state_q <= HDR;
              dcnt_q  <= dcnt_q + 32'd1;
            end else begin
              state_q  <= HOLD;
              valid_q  <= 1'b1;
              tready_q <= 1'b0;
            end
          end else if (bus.s_axis_tlast) begin
            state_q <= HDR;
            wcnt_q  <= '0;
            dcnt_q  <= dcnt_q + 32'd1;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
            if (bus.s_axis_tkeep != 4'hF) bad_q <= 1'b1;
          end
        end
        HOLD: if (bus.rvvi_ready) begin
          state_q  <= HDR;
          valid_q  <= 1'b0;
          tready_q <= 1'b1;
          fcnt_q   <= fcnt_q + 32'd1;
        end
        DRAIN: if (accept && bus.s_axis_tlast) begin
          state_q <= HDR;
          wcnt_q  <= '0;
        end
        default: state_q <= HDR;
      endcase
    end
  end

  // Record buffer, one register per payload word; the last word keeps only the
  // bits inside RVVI_W. Only PAY writes it, so the record is stable in HOLD.
  for (genvar k = 0; k < NW; k++) begin : g_word
    localparam int LO = 32 * k;
    localparam int WB = (RVVI_W - LO < 32) ? (RVVI_W - LO) : 32;
    logic [WB-1:0] word_q;

    // Capture payload word k when it is handshaken.
    always_ff @(posedge clk) begin
      if (reset)                          word_q <= '0;
      else if (pay_ld && pidx == WCW'(k)) word_q <= bus.s_axis_tdata[WB-1:0];
    end

    assign rec[LO +: WB] = word_q;
  end

  assign bus.s_axis_tready = tready_q;
  assign bus.rvvi          = rec;
  assign bus.rvvi_valid    = valid_q;
  assign bus.FrameCount    = fcnt_q;
  assign bus.DropCount     = dcnt_q;

endmodule

// File: tb/tb_rvvi_depacketizer.sv
// Scoreboard bench for rvvi_depacketizer (XLEN=64, MAX_CSRS=5: 792-bit record, 29-word frame).
module tb_rvvi_depacketizer;
  import rvvi_depacketizer_pkg::*;

  localparam int RW = rvvi_width(64, 5);
  localparam int NW = rvvi_words(RW);
  localparam int FW = HDR_WORDS + NW;
  localparam logic [47:0] MY_MAC    = DEST_MAC_DEFAULT;
  localparam logic [47:0] SRC_MAC   = 48'h0200_0000_0001;
  localparam logic [47:0] OTHER_MAC = 48'h0211_2233_4455;

  logic clk = 1'b0;
  logic reset = 1'b1;

  rvvi_depacketizer_if #(.RVVI_W(RW)) bus ();

  rvvi_depacketizer #(
    .P         (CVW_DEFAULT),
    .MAX_CSRS  (5),
    .ETHERTYPE (16'h005C)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_vec  = 0;
  int          n_bad  = 0;
  int          stalls = 0;
  logic [31:0] exp_fc = '0;
  logic [31:0] exp_dc = '0;
  logic [RW-1:0] sb [$];
  logic [31:0]   fw [FW+1];

  task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic check_cnt(input string tag);
    chk({tag, "_fc"}, RW'(bus.FrameCount), RW'(exp_fc));
    chk({tag, "_dc"}, RW'(bus.DropCount), RW'(exp_dc));
  endtask

  function automatic logic [RW-1:0] rand_rec();
    logic [NW*32-1:0] p;
    for (int k = 0; k < NW; k++) p[32*k +: 32] = $urandom();
    return p[RW-1:0];
  endfunction

  // Fill fw[] with header + payload (+ one spare word); garbage above RW in the last word.
  task automatic build_frame(input logic [RW-1:0] rec, input logic [47:0] dmac, input logic [15:0] et);
    logic [NW*32-1:0] p;
    logic [7:0]       hb [16];
    p = {{(NW*32-RW){1'b0}}, rec};
    for (int b = RW; b < NW*32; b++) p[b] = 1'($urandom_range(0, 1));
    for (int i = 0; i < 6; i++) begin
      hb[i]     = dmac[47-8*i -: 8];
      hb[6 + i] = SRC_MAC[47-8*i -: 8];
    end
    hb[12] = et[15:8];
    hb[13] = et[7:0];
    hb[14] = 8'h00;
    hb[15] = 8'h00;
    for (int i = 0; i < HDR_WORDS; i++) fw[i] = {hb[4*i+3], hb[4*i+2], hb[4*i+1], hb[4*i]};
    for (int k = 0; k < NW; k++) fw[HDR_WORDS + k] = p[32*k +: 32];
    fw[FW] = $urandom();
  endtask

  // Present one word and hold it until handshaken; call at posedge+1.
  task automatic put(input logic [31:0] d, input logic [3:0] keep, input logic last, input logic user);
    int n;
    n = 0;
    bus.s_axis_tdata  = d;
    bus.s_axis_tkeep  = keep;
    bus.s_axis_tlast  = last;
    bus.s_axis_tuser  = user;
    bus.s_axis_tvalid = 1'b1;
    @(negedge clk);
    while (bus.s_axis_tready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("tready_timeout", RW'(0), RW'(1));
    stalls += n;
    @(posedge clk);
    #1;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tuser  = 1'b0;
  endtask

  task automatic send_frame(input logic [RW-1:0] rec, input logic [47:0] dmac, input logic [15:0] et,
                            input int len, input logic user, input int badkeep, input logic good);
    build_frame(rec, dmac, et);
    for (int i = 0; i < len; i++)
      put((i <= FW) ? fw[i] : $urandom(), (i == badkeep) ? 4'h7 : 4'hF, i == len - 1,
          user && (i == len - 1));
    @(negedge clk);
    chk("valid_latency", RW'(bus.rvvi_valid), RW'(good));
    @(posedge clk);
    #1;
  endtask

  task automatic send_good(input logic [47:0] dmac);
    logic [RW-1:0] r;
    r = rand_rec();
    sb.push_back(r);
    exp_fc++;
    send_frame(r, dmac, 16'h005C, FW, 1'b0, -1, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare each delivered record against the oldest expected one.
  always @(negedge clk) begin
    if (!reset && bus.rvvi_valid && bus.rvvi_ready) begin
      if (sb.size() == 0) chk("unexpected_record", RW'(1), RW'(0));
      else                chk("record", bus.rvvi, sb.pop_front());
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RW-1:0] r;
    logic          ok;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tkeep  = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tuser  = 1'b0;
    bus.rvvi_ready    = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tready", RW'(bus.s_axis_tready), RW'(0));
    chk("rst_valid",  RW'(bus.rvvi_valid), RW'(0));
    chk("rst_rvvi",   bus.rvvi, '0);
    check_cnt("rst");
    @(posedge clk);
    #1 reset = 1'b0;
    idle(1);

    // 1: good frame delivered one cycle after the last word
    send_good(MY_MAC);
    idle(3);
    check_cnt("t1");

    // 2: wrong EtherType drained without back-pressure, then a good frame
    stalls = 0;
    exp_dc++;
    send_frame(rand_rec(), MY_MAC, 16'h0800, FW, 1'b0, -1, 1'b0);
    chk("t2_no_stall", RW'(stalls), RW'(0));
    idle(2);
    check_cnt("t2");
    send_good(MY_MAC);
    idle(3);
    check_cnt("t2b");

    // 3: short frame (tlast on payload word 10), long frame, tuser error, bad tkeep
    exp_dc++;
    send_frame(rand_rec(), MY_MAC, 16'h005C, HDR_WORDS + 11, 1'b0, -1, 1'b0);
    idle(2);
    check_cnt("t3_short");
    exp_dc++;
    send_frame(rand_rec(), MY_MAC, 16'h005C, FW + 1, 1'b0, -1, 1'b0);
    idle(2);
    check_cnt("t3_long");
    exp_dc++;
    send_frame(rand_rec(), MY_MAC, 16'h005C, FW, 1'b1, -1, 1'b0);
    exp_dc++;
    send_frame(rand_rec(), MY_MAC, 16'h005C, FW, 1'b0, HDR_WORDS + 10, 1'b0);
    idle(2);
    check_cnt("t3_err");
    send_good(MY_MAC);
    idle(3);
    check_cnt("t3b");

    // 4: consumer stalls 50 cycles; record held, stream stalled; back-to-back frame kept
    bus.rvvi_ready = 1'b0;
    r = rand_rec();
    sb.push_back(r);
    exp_fc++;
    send_frame(r, MY_MAC, 16'h005C, FW, 1'b0, -1, 1'b1);
    ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (bus.s_axis_tready !== 1'b0 || bus.rvvi_valid !== 1'b1 || bus.rvvi !== r) ok = 1'b0;
    end
    chk("t4_hold_stable", RW'(ok), RW'(1));
    chk("t4_fc_waiting", RW'(bus.FrameCount), RW'(exp_fc - 32'd1));
    @(posedge clk);
    #1;
    fork
      send_good(MY_MAC);
      begin
        repeat (3) @(posedge clk);
        #1 bus.rvvi_ready = 1'b1;
      end
    join
    idle(3);
    check_cnt("t4");

    // 5: reset during payload word 12; trailing words form a foreign-EtherType frame
    build_frame(rand_rec(), MY_MAC, 16'h005C);
    for (int i = 0; i < HDR_WORDS + 12; i++) put(fw[i], 4'hF, 1'b0, 1'b0);
    bus.s_axis_tdata  = fw[HDR_WORDS + 12];
    bus.s_axis_tvalid = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1 bus.s_axis_tvalid = 1'b0;
    exp_fc = '0;
    exp_dc = '0;
    @(negedge clk);
    chk("t5_tready", RW'(bus.s_axis_tready), RW'(0));
    chk("t5_valid",  RW'(bus.rvvi_valid), RW'(0));
    chk("t5_rvvi",   bus.rvvi, '0);
    check_cnt("t5_rst");
    @(posedge clk);
    #1 reset = 1'b0;
    fw[HDR_WORDS + 13] = fw[0];
    fw[HDR_WORDS + 14] = fw[1];
    fw[HDR_WORDS + 16] = 32'h0000_0008;
    for (int i = HDR_WORDS + 13; i < FW; i++) put(fw[i], 4'hF, i == FW - 1, 1'b0);
    exp_dc++;
    idle(2);
    check_cnt("t5_tail");
    send_good(MY_MAC);
    idle(3);
    check_cnt("t5b");

    // 6: foreign destination MAC
`ifdef RVVI_DEPKT_MACFILTER_EN
    send_frame(rand_rec(), OTHER_MAC, 16'h005C, FW, 1'b0, -1, 1'b0);
`else
    send_good(OTHER_MAC);
`endif
    idle(3);
    check_cnt("t6");
    send_good(MY_MAC);
    idle(3);
    check_cnt("t6b");

    chk("sb_empty", RW'(sb.size()), RW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
